chunked_serial_adder: RTL and testbench



---
 rtl/chunked_serial_adder.sv | 115 +++++++++++
 tb/tb_chunked_serial_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor. It processes CHUNK bits per clock, starting with the LSB chunk,
// and keeps the carry between chunks in a register. Control is a start/busy/done handshake.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             last_chunk;
    int unsigned      idx;

    // Chunk adder for the current counter position, plus the merged internal result
    always_comb begin
        idx        = 32'(cnt_q) * CHUNK;
        chunk_a    = CHUNK'(opa_q >> idx);
        chunk_b    = CHUNK'(opb_q >> idx);
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        // carry into the chunk's top bit; on the last chunk this is the carry into bit WIDTH-1
        msb_cin    = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last_chunk = (cnt_q == CW'(N - 1));
        res_d      = res_q;
        res_d[idx +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Handshake FSM, operand/carry capture, chunk accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // subtraction is computed as a + ~b + ~c_in
                        opa_q   <= a;
                        opb_q   <= b ^ {WIDTH{sub}};
                        carry_q <= c_in ^ sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_chunk) begin
                        sum_q   <= res_d;
                        c_out_q <= chunk_sum[CHUNK];
                        ovf_q   <= msb_cin ^ chunk_sum[CHUNK];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed testbench for chunked_serial_adder with WIDTH=16 and CHUNK=4 (4 cycles per operation).
module tb_chunked_serial_adder;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[12];

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [W-1:0] s,
                                      input logic co, input logic ov);
        check({tag, " busy"}, 32'(busy), 32'(0));
        check({tag, " done"}, 32'(done), 32'(0));
        check({tag, " sum"}, 32'(sum), 32'(s));
        check({tag, " c_out"}, 32'(c_out), 32'(co));
        check({tag, " ovf"}, 32'(ovf), 32'(ov));
    endtask

    // Run one operation. Check busy and done through the RUN cycles, then check the result
    // in the done cycle, then check that done has dropped.
    task automatic run_op(input string tag, input vec_t v, input logic [W-1:0] prev_s);
        @(negedge clk);
        a = v.a; b = v.b; c_in = v.cin; sub = v.sub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check({tag, " busy run"}, 32'(busy), 32'(1));
            check({tag, " done run"}, 32'(done), 32'(0));
            check({tag, " sum held"}, 32'(sum), 32'(prev_s));
        end
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'(1));
        check({tag, " busy end"}, 32'(busy), 32'(0));
        check({tag, " sum"}, 32'(sum), 32'(v.s));
        check({tag, " c_out"}, 32'(c_out), 32'(v.co));
        check({tag, " ovf"}, 32'(ovf), 32'(v.ov));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [W-1:0] prev;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle", 16'h0000, 1'b0, 1'b0);

        prev = 16'h0000;
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i], prev);
            prev = vecs[i].s;
        end

        // Handshake: start is held high while busy, so it is ignored until the done cycle accepts it
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h1000; b = 16'h1000;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("hs busy1", 32'(busy), 32'(1));
            check("hs done1 low", 32'(done), 32'(0));
        end
        @(negedge clk);
        check("hs done1", 32'(done), 32'(1));
        check("hs sum1", 32'(sum), 32'(16'h0002));
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("hs busy2", 32'(busy), 32'(1));
            check("hs done2 low", 32'(done), 32'(0));
            check("hs sum held", 32'(sum), 32'(16'h0002));
        end
        @(negedge clk);
        check("hs done2", 32'(done), 32'(1));
        check("hs sum2", 32'(sum), 32'(16'h2000));
        check("hs c_out2", 32'(c_out), 32'(0));
        @(negedge clk);
        check("hs done2 pulse", 32'(done), 32'(0));

        // Asynchronous reset in the second RUN cycle
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        check("ar busy before", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check_idle_outputs("ar immediate", 16'h0000, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            check("ar no done", 32'(done), 32'(0));
            check("ar no busy", 32'(busy), 32'(0));
            check("ar sum zero", 32'(sum), 32'(0));
        end
        run_op("ar fresh", '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
